// File: rtl/rv32i_intc_pkg.sv
// Shared constants and FSM state type for the rv32i interrupt controller.
package intc_pkg;

  localparam int MAX_SRC = 16;

  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_CLAIM   = 3'd3;
  localparam logic [2:0] REG_FORCE   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/rv32i_intc_if.sv
// Register bus, raw sources and claim/complete handshake between rv32i_control and the controller.
interface rv32i_intc_if #(
  parameter int NUM_SRC = 5,
  parameter int ID_BITS = 4
);
  logic [NUM_SRC-1:0] src_i;
  logic [2:0]         addr_i;
  logic [15:0]        data_i;
  logic               write_i;
  logic               read_i;
  logic [15:0]        data_o;
  logic               irq_o;
  logic [ID_BITS-1:0] irq_id_o;
  logic               ack_i;
  logic               eoi_i;
  logic               in_service_o;

  modport master (
    output src_i, addr_i, data_i, write_i, read_i, ack_i, eoi_i,
    input  data_o, irq_o, irq_id_o, in_service_o
  );

  modport slave (
    input  src_i, addr_i, data_i, write_i, read_i, ack_i, eoi_i,
    output data_o, irq_o, irq_id_o, in_service_o
  );
endinterface

// File: rtl/rv32i_intc_src_cond.sv
// Per-source conditioning: optional 2-flop synchronizer (INTC_SYNC_EN), history flop,
// rising-edge pulse and level outputs.
module intc_src_cond (
  input  logic clk_i,
  input  logic reset_i,
  input  logic src_i,
  output logic rise_o,
  output logic level_o
);

  logic cond;
  logic prev_q, prev_d;

`ifdef INTC_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = src_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign cond = sync2_q;
`else
  assign cond = src_i;
`endif

  always_comb prev_d = cond;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end

  assign rise_o  = cond & ~prev_q;
  assign level_o = cond;

endmodule

// File: rtl/rv32i_intc.sv
// Interrupt controller: edge/level pending, enable mask, fixed priority (lowest index wins),
// claim/complete FSM and a 16-bit register bank. INTC_SYNC_EN adds source synchronizers.
module rv32i_intc #(
  parameter int NUM_SRC = 5,
  parameter int ID_BITS = 4
) (
  input logic          clk_i,
  input logic          reset_i,
  rv32i_intc_if.slave  bus
);
  import intc_pkg::*;

  logic [NUM_SRC-1:0] rise, level, elig;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [ID_BITS-1:0] active_id_q, active_id_d;
  logic [ID_BITS-1:0] top_id, irq_id;
  logic [15:0]        data_q, data_d, rd_val;
  state_e             state_q, state_d;
  logic               any_elig, ack_take;
  logic               wr_enable, wr_pend, wr_mode, wr_claim, wr_force;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intc_src_cond u_cond (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .src_i   (bus.src_i[g]),
      .rise_o  (rise[g]),
      .level_o (level[g])
    );
  end

  assign wr_enable    = bus.write_i && (bus.addr_i == REG_ENABLE);
  assign wr_pend      = bus.write_i && (bus.addr_i == REG_PENDING);
  assign wr_mode      = bus.write_i && (bus.addr_i == REG_MODE);
  assign wr_claim     = bus.write_i && (bus.addr_i == REG_CLAIM);
  assign wr_force     = bus.write_i && (bus.addr_i == REG_FORCE);
  assign unused_wdata = ^bus.data_i;

  assign elig     = pend_q & enable_q;
  assign any_elig = |elig;

  always_comb begin
    top_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) top_id = ID_BITS'(i);
    end
  end

  always_comb begin
    irq_id = '0;
    if (state_q == REQ)          irq_id = top_id;
    else if (state_q == SERVICE) irq_id = active_id_q;
  end

  // An ack only claims when something is still eligible; otherwise REQ falls back to IDLE.
  assign ack_take = bus.ack_i && (state_q == REQ) && any_elig;

  always_comb begin
    enable_d = wr_enable ? bus.data_i[NUM_SRC-1:0] : enable_q;
    mode_d   = wr_mode   ? bus.data_i[NUM_SRC-1:0] : mode_q;
    pend_d   = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = rise[i] | (wr_force & bus.data_i[i]) |
                    (pend_q[i] & ~((wr_pend & bus.data_i[i]) |
                                   (ack_take && (top_id == ID_BITS'(i)))));
      end else begin
        pend_d[i] = level[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      IDLE:    if (any_elig) state_d = REQ;
      REQ: begin
        if (!any_elig) begin
          state_d = IDLE;
        end else if (bus.ack_i) begin
          state_d     = SERVICE;
          active_id_d = top_id;
        end
      end
      SERVICE: if (bus.eoi_i || wr_claim) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr_i)
      REG_ENABLE:  rd_val = 16'(enable_q);
      REG_PENDING: rd_val = 16'(pend_q);
      REG_MODE:    rd_val = 16'(mode_q);
      REG_CLAIM: begin
        rd_val     = 16'(irq_id);
        rd_val[15] = (state_q == SERVICE);
      end
      default:     rd_val = '0;
    endcase
    data_d = bus.read_i ? rd_val : data_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enable_q    <= '0;
      mode_q      <= '0;
      pend_q      <= '0;
      active_id_q <= '0;
      data_q      <= '0;
      state_q     <= IDLE;
    end else begin
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      active_id_q <= active_id_d;
      data_q      <= data_d;
      state_q     <= state_d;
    end
  end

  assign bus.irq_o        = (state_q == REQ);
  assign bus.in_service_o = (state_q == SERVICE);
  assign bus.irq_id_o     = irq_id;
  assign bus.data_o       = data_q;

endmodule

// File: doc/rv32i_intc.md
# rv32i_intc

Parametrised interrupt controller for the rv32i core, replacing the fixed 5-bit interrupt vector/mask pair in the general peripheral region. It conditions up to 16 sources (per-channel edge or level mode), latches pending state, applies an enable mask, and presents one fixed-priority request with a claim/complete handshake to `rv32i_control`. Software sees it as a 16-bit memory-mapped register bank.

## Interface
- `NUM_SRC`, 5: number of interrupt sources, 1..16.
- `ID_BITS`, 4: width of the source ID; must satisfy 2^ID_BITS >= NUM_SRC.
- `clk_i` in 1: system clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `src_i` in NUM_SRC: raw interrupt sources (timer, gpu, ...).
- `addr_i` in 3: halfword register index (memory_addr[3:1]).
- `data_i` in 16: write data.
- `write_i` in 1: register write strobe, region-decoded.
- `read_i` in 1: register read strobe, region-decoded.
- `data_o` out 16: read data.
- `irq_o` out 1: interrupt request to control.
- `irq_id_o` out ID_BITS: ID of the highest-priority request.
- `ack_i` in 1: control takes the interrupt (claim).
- `eoi_i` in 1: control returns from the handler (complete).
- `in_service_o` out 1: a claimed interrupt is in service.

## Operation
- Registers (index, bits [NUM_SRC-1:0], upper bits read 0):
  - 0 ENABLE: R/W mask.
  - 1 PENDING: R; write-1-to-clear, edge channels only.
  - 2 MODE: R/W; 1 = rising edge, 0 = level high.
  - 3 CLAIM: R returns {in_service, 11'b0, active ID}; any write acts as `eoi_i`.
  - 4 FORCE: W-1 sets PENDING, edge channels only; reads 0.
  - Indices 5–7: reads 0, writes ignored.
- Edge channel: pending sets on 0→1 of the conditioned source; clears on W1C or on `ack_i` claiming that ID. If set and clear occur together, set wins.
- Level channel: pending equals the registered conditioned source; W1C, FORCE and ack have no effect.
- Eligible = pending & enable. Priority is fixed: the lowest index wins.
- FSM:
  - IDLE → REQ when eligible ≠ 0.
  - REQ → IDLE when eligible becomes 0 before ack.
  - REQ → SERVICE on `ack_i`; the active ID latches `irq_id_o` of that cycle.
  - SERVICE → IDLE on `eoi_i` or a CLAIM write.
- `irq_o` = (state == REQ). `in_service_o` = (state == SERVICE).
- `irq_id_o` tracks the current highest eligible ID every cycle in REQ and holds the active ID in SERVICE.
- `ack_i` outside REQ and `eoi_i` outside SERVICE are ignored.
- No preemption: requests arriving in SERVICE stay pending.

## Timing
- Reset values: all registers 0, state IDLE, `irq_o` 0, `irq_id_o` 0, `in_service_o` 0, `data_o` 0, edge-detect history 0.
- Reset mid-service drops to IDLE immediately and clears all pending.
- Source-to-request latency, source high at edge k:
  - Pending is visible at k+1.
  - `irq_o` is high after edge k+2.
  - With INTC_SYNC_EN defined, add 2 cycles.
- Ack: `ack_i` at edge k gives SERVICE and the pending clear both at k+1. `irq_o` is low after k.
- EOI: `eoi_i` at edge k gives IDLE at k+1. A remaining eligible source re-raises `irq_o` at k+2.
- Reads: `data_o` is registered, valid the cycle after `read_i`, and holds its value otherwise.
- Writes take effect at the strobe edge. An ENABLE write that clears the only eligible bit in REQ drops `irq_o` the next cycle.

## Configuration
- `INTC_SYNC_EN` defined: each source passes through a 2-flop synchronizer (reset 0) before edge detection. Use this for sources from other clock domains.
- `INTC_SYNC_EN` undefined: sources are used directly and must be synchronous to `clk_i`.

## Structure
- Package `intc_pkg` holds:
  - register index constants (ENABLE, PENDING, MODE, CLAIM, FORCE);
  - FSM state typedef (IDLE, REQ, SERVICE);
  - maximum source count constant.
- Sub-module `intc_src_cond` (per channel): optional synchronizer, previous-value flop, and rise pulse and level outputs. It is generated NUM_SRC times. The top holds the registers, priority encoder and FSM.

## Test plan
- Enable 0x3, MODE 0x3, pulse `src_i[1]` then `src_i[0]` 1 cycle apart:
  - `irq_o` rises with `irq_id_o` = 1, then switches to 0 before ack.
  - `ack_i` claims 0; PENDING reads 0x2.
- Level channel 2, enable 0x4, hold `src_i[2]` high:
  - `irq_o` after 2 cycles.
  - Ack then `eoi_i` with the source still high re-raises `irq_o` 2 cycles after EOI.
  - Deassert the source in REQ: `irq_o` drops 2 cycles later.
- FORCE write 0x10 with channel 4 in edge mode and enabled → `irq_id_o` = 4.
  - W1C PENDING 0x10 in the same cycle as a `src_i[4]` rise → PENDING stays 0x10.
- In SERVICE (ID 0), raise source 1:
  - `irq_o` stays low; CLAIM reads 0x8000.
  - A CLAIM write gives `irq_o` with ID 1 two cycles later.
- Assert `reset_i` mid-SERVICE: `in_service_o`, `irq_o` and PENDING are 0 asynchronously; `ack_i`/`eoi_i` pulses in IDLE have no effect.
- With INTC_SYNC_EN defined, edge source at edge k → `irq_o` at k+4.
